// File: rtl/sigdel_pkg.sv
// Shared definitions for the sigdel serial link: ADC word width, default bit
// period and the receiver state encoding.
package sigdel_pkg;

  localparam int ADC_W            = 12;
  localparam int DEF_CLKS_PER_BIT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/sigdel_ser_rx_sync2.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle
// (high) level so a reset never looks like a start edge.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sigdel_ser_rx.sv
// Serial receiver for sigdel ADC frames: start bit, DATA_W bits LSB first,
// stop bit. Mid-bit sampling, held result with ack, framing/overrun flags.
module sigdel_ser_rx
  import sigdel_pkg::*;
#(
  parameter int DATA_W       = ADC_W,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_i,
  input  logic              rd_ack,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              ferr_o,
  output logic              ovr_o,
  output logic              busy_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);

  rx_state_t         state;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] shreg;
  logic              rx_s;
  logic              rx_prev;
  logic              fall;

  sync2 u_sync2 (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx_i),
    .q     (rx_s)
  );

  assign fall = rx_prev & ~rx_s;

  // Completion is written after the ack clear so a coinciding good stop
  // sample wins: the new word is marked valid and overrun stays clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      shreg   <= '0;
      rx_prev <= 1'b1;
      data_o  <= '0;
      valid_o <= 1'b0;
      ferr_o  <= 1'b0;
      ovr_o   <= 1'b0;
      busy_o  <= 1'b0;
    end else begin
      rx_prev <= rx_s;
      ferr_o  <= 1'b0;

      if (rd_ack && valid_o) begin
        valid_o <= 1'b0;
        ovr_o   <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (fall) begin
            state  <= START;
            cnt    <= '0;
            busy_o <= 1'b1;
          end
        end

        START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (!rx_s) begin
              state <= DATA;
              idx   <= '0;
            end else begin
              state  <= IDLE;
              busy_o <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        DATA: begin
          if (cnt == BIT_LAST) begin
            shreg[idx] <= rx_s;
            cnt        <= '0;
            if (idx == IDX_LAST) begin
              state <= STOP;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        STOP: begin
          if (cnt == BIT_LAST) begin
            state  <= IDLE;
            cnt    <= '0;
            busy_o <= 1'b0;
            if (rx_s) begin
              data_o  <= shreg;
              valid_o <= 1'b1;
              if (valid_o && !rd_ack) begin
                ovr_o <= 1'b1;
              end
            end else begin
              ferr_o <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sigdel_ser_rx.sv
// Directed bench for sigdel_ser_rx at default parameters: frame latency,
// ack handling, overrun, framing error, start glitch and mid-frame reset.
module tb_sigdel_ser_rx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_i;
  logic        rd_ack;
  logic [11:0] data_o;
  logic        valid_o;
  logic        ferr_o;
  logic        ovr_o;
  logic        busy_o;

  int compared   = 0;
  int mismatched = 0;
  int ferrCount  = 0;
  int busyCount  = 0;

  sigdel_ser_rx dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx_i    (rx_i),
    .rd_ack  (rd_ack),
    .data_o  (data_o),
    .valid_o (valid_o),
    .ferr_o  (ferr_o),
    .ovr_o   (ovr_o),
    .busy_o  (busy_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ferr_o) ferrCount++;
    if (busy_o) busyCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Called at a negedge; the next posedge is E0. Samples valid_o just after
  // E0+217 and E0+218, then returns at the negedge that ends the stop bit.
  task automatic applyStimulus(input logic [11:0] word, input logic stopBit,
                               output logic v217, output logic v218,
                               output logic [11:0] d218, output logic o218);
    rx_i = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      rx_i = word[i];
      repeat (16) @(negedge clk);
    end
    rx_i = stopBit;
    repeat (10) @(posedge clk);
    #1 v217 = valid_o;
    @(posedge clk);
    #1;
    v218 = valid_o;
    d218 = data_o;
    o218 = ovr_o;
    repeat (6) @(negedge clk);
    rx_i = 1'b1;
  endtask

  task automatic pulseAck();
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic        v217, v218, o218;
    logic [11:0] d218;
    logic [11:0] partWord;
    int          ferrBefore;

    rst_n  = 1'b0;
    rx_i   = 1'b1;
    rd_ack = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_data",  32'(data_o),  32'h0);
    checkOutput("rst_valid", 32'(valid_o), 32'h0);
    checkOutput("rst_ferr",  32'(ferr_o),  32'h0);
    checkOutput("rst_ovr",   32'(ovr_o),   32'h0);
    checkOutput("rst_busy",  32'(busy_o),  32'h0);

    rst_n = 1'b1;
    busyCount = 0;
    repeat (100) @(negedge clk);
    checkOutput("idle_busy_cycles", 32'(busyCount), 32'd0);
    checkOutput("idle_valid", 32'(valid_o), 32'h0);
    checkOutput("idle_data",  32'(data_o),  32'h0);

    applyStimulus(12'hA5C, 1'b1, v217, v218, d218, o218);
    checkOutput("a5c_valid_e217", 32'(v217), 32'h0);
    checkOutput("a5c_valid_e218", 32'(v218), 32'h1);
    checkOutput("a5c_data",       32'(d218), 32'hA5C);
    checkOutput("a5c_ovr",        32'(o218), 32'h0);
    checkOutput("a5c_ferr_count", 32'(ferrCount), 32'd0);
    pulseAck();
    checkOutput("ack_valid", 32'(valid_o), 32'h0);
    checkOutput("ack_data",  32'(data_o),  32'hA5C);
    pulseAck();
    checkOutput("ack_idle_valid", 32'(valid_o), 32'h0);
    checkOutput("ack_idle_ovr",   32'(ovr_o),   32'h0);

    applyStimulus(12'h001, 1'b1, v217, v218, d218, o218);
    checkOutput("b2b1_valid", 32'(v218), 32'h1);
    checkOutput("b2b1_data",  32'(d218), 32'h001);
    checkOutput("b2b1_ovr",   32'(o218), 32'h0);
    applyStimulus(12'hFFE, 1'b1, v217, v218, d218, o218);
    checkOutput("b2b2_valid", 32'(v218), 32'h1);
    checkOutput("b2b2_data",  32'(d218), 32'hFFE);
    checkOutput("b2b2_ovr",   32'(o218), 32'h1);
    pulseAck();
    checkOutput("b2b_ack_valid", 32'(valid_o), 32'h0);
    checkOutput("b2b_ack_ovr",   32'(ovr_o),   32'h0);

    ferrBefore = ferrCount;
    applyStimulus(12'h3C3, 1'b0, v217, v218, d218, o218);
    checkOutput("ferr_valid", 32'(v218), 32'h0);
    checkOutput("ferr_data",  32'(d218), 32'hFFE);
    checkOutput("ferr_ovr",   32'(o218), 32'h0);
    repeat (4) @(negedge clk);
    checkOutput("ferr_pulse_cycles", 32'(ferrCount - ferrBefore), 32'd1);

    repeat (20) @(negedge clk);
    ferrBefore = ferrCount;
    rx_i = 1'b0;
    repeat (3) @(negedge clk);
    rx_i = 1'b1;
    checkOutput("glitch_busy_start", 32'(busy_o), 32'h1);
    repeat (10) @(negedge clk);
    checkOutput("glitch_busy_end", 32'(busy_o), 32'h0);
    checkOutput("glitch_valid",    32'(valid_o), 32'h0);
    checkOutput("glitch_ferr",     32'(ferrCount - ferrBefore), 32'd0);
    checkOutput("glitch_data",     32'(data_o), 32'hFFE);

    partWord = 12'h555;
    rx_i = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      rx_i = partWord[i];
      repeat (16) @(negedge clk);
    end
    rx_i = partWord[5];
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    rx_i  = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("midrst_busy", 32'(busy_o), 32'h0);
    checkOutput("midrst_data", 32'(data_o), 32'h0);
    rst_n = 1'b1;
    repeat (240) @(negedge clk);
    checkOutput("midrst_valid_after", 32'(valid_o), 32'h0);
    checkOutput("midrst_busy_after",  32'(busy_o),  32'h0);

    applyStimulus(12'h800, 1'b1, v217, v218, d218, o218);
    checkOutput("post_rst_valid_e217", 32'(v217), 32'h0);
    checkOutput("post_rst_valid_e218", 32'(v218), 32'h1);
    checkOutput("post_rst_data",       32'(d218), 32'h800);
    checkOutput("post_rst_ovr",        32'(o218), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
